// File: rtl/serial_addsub16.sv
// Bit-serial adder/subtractor: one bit per clock through a single full adder,
// LSB first, with the carry held in a flip-flop between bits.

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_addsub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             cmsb;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             msb_bit;
    logic [WIDTH-1:0] acc_next;

    fulladder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign msb_bit  = (cnt == CW'(WIDTH - 2));
    assign acc_next = {fa_sum, acc[WIDTH-1:1]};

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            cmsb     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // subtract as a + ~b + 1
                        sa    <= a;
                        sb    <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    acc   <= acc_next;
                    carry <= fa_cout;
                    if (msb_bit) begin
                        cmsb <= fa_cout;
                    end
                    if (last_bit) begin
                        result   <= acc_next;
                        cout     <= fa_cout;
                        overflow <= cmsb ^ fa_cout;
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub16.sv
// Directed self-checking bench for serial_addsub16 (WIDTH=16).
// Outputs are sampled on the falling edge; inputs change away from rising edges.

module tb_serial_addsub16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;

    int ncmp;
    int nerr;
    int cyc;
    int n;
    int ndone;
    int t_prev;

    serial_addsub16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, check latency and outputs.
    task automatic do_op(input string tag, input logic [15:0] ta,
                         input logic [15:0] tb_v, input logic ts,
                         input logic [15:0] er, input logic ec,
                         input logic eo);
        int k;
        logic [15:0] held;
        @(negedge clk);
        a = ta;
        b = tb_v;
        sub = ts;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = ~ts;
        held = result;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            if (done) break;
            if (k == 8) begin
                chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
                chk({tag, "_stable"}, {16'd0, result}, {16'd0, held});
            end
            k++;
        end
        chk({tag, "_latency"}, k, 16);
        chk({tag, "_ready_in_done"}, {31'd0, ready}, 32'd0);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, er});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = 16'h0;
        b = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        do_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start pulses during RUN and during DONE must be ignored
        @(negedge clk);
        a = 16'h1234;
        b = 16'h4321;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        sub = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                a = 16'h0F0F;
                b = 16'h0101;
                sub = 1'b1;
                start = 1'b1;
            end
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_result", {16'd0, result}, 32'h5555);
        chk("ign_cout", {31'd0, cout}, 32'd0);
        chk("ign_ready", {31'd0, ready}, 32'd1);

        // reset after 8 RUN cycles aborts without done
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0F00;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // back-to-back with start held high
        @(negedge clk);
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0010;
        b = 16'h0001;
        sub = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                if (done) break;
                n++;
            end
            chk("b2b_done_seen", {31'd0, done}, 32'd1);
            if (k > 0) chk("b2b_period", cyc - t_prev, 18);
            t_prev = cyc;
            unique case (k)
                0: begin
                    chk("b2b_r0", {16'd0, result}, 32'h3333);
                    chk("b2b_c0", {31'd0, cout}, 32'd0);
                end
                1: begin
                    chk("b2b_r1", {16'd0, result}, 32'h000F);
                    chk("b2b_c1", {31'd0, cout}, 32'd1);
                    chk("b2b_o1", {31'd0, overflow}, 32'd0);
                end
                default: begin
                    chk("b2b_r2", {16'd0, result}, 32'hBCDE);
                    chk("b2b_c2", {31'd0, cout}, 32'd0);
                end
            endcase
            @(negedge clk);
            @(negedge clk);
            if (k == 0) begin
                a = 16'hABCD;
                b = 16'h1111;
                sub = 1'b0;
            end else begin
                start = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
